// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with start-glitch rejection, framing-error and break handling
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       en_data_out,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
  logic          rx_m, rx_s, rx_d;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  assign busy = state != IDLE;
  // two-flop synchroniser plus one delay flop for falling-edge detection; idle-high reset avoids a false start
  always_ff @(posedge clk or negedge res)
    if (!res) {rx_d, rx_s, rx_m} <= 3'b111;
    else {rx_d, rx_s, rx_m} <= {rx_s, rx_m, RX};
  // frame FSM: mid-bit sampling, byte assembly and single-cycle result strobes
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      data_out <= '0;
      en_data_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      en_data_out <= 1'b0;
      frame_err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_d & ~rx_s) state <= START;
        end
        START:
          if (cnt == MID) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (cnt == LAST) begin
            cnt <= '0;
            shift <= {rx_s, shift[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        STOP:
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shift;
              en_data_out <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state <= BRK;
            end
          end
        BRK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed self-checking bench for uart_rx_frame at 16 clocks per bit
module tb_uart_rx_frame;
  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] data_out;
  logic       en_data_out, frame_err, busy;
  int checks = 0, errors = 0;
  int cyc = 0;
  int en_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic [7:0] en_data [64];
  int en_cyc [64];
  uart_rx_frame #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .res(res), .RX(RX), .data_out(data_out),
    .en_data_out(en_data_out), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  // cycle counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;
  // pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (en_data_out) begin
      en_data[en_cnt % 64] <= data_out;
      en_cyc[en_cnt % 64] <= cyc;
      en_cnt <= en_cnt + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (en_data_out && frame_err) both_cnt <= both_cnt + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      tick(16);
    end
  endtask
  task automatic test_reset;
    tick(3);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (en_data_out !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", en_data_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    res = 1'b1;
    tick(5);
  endtask
  task automatic test_single;
    int e0, f0, start;
    e0 = en_cnt; f0 = fe_cnt; start = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        tick(80);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      end
    join
    tick(20);
    checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", en_cnt - e0); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", data_out); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", fe_cnt - f0); end
    checks++;
    if (en_cnt - e0 < 1 || en_cyc[e0 % 64] - start < 153 || en_cyc[e0 % 64] - start > 157) begin
      errors++; $display("FAIL latency: got %0d want 155+/-2", en_cyc[e0 % 64] - start);
    end
  endtask
  task automatic test_back_to_back;
    int e0;
    e0 = en_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(20);
    checks++; if (en_cnt - e0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", en_cnt - e0); end
    checks++; if (en_data[e0 % 64] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", en_data[e0 % 64]); end
    checks++; if (en_data[(e0 + 1) % 64] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", en_data[(e0 + 1) % 64]); end
    checks++;
    if (en_cyc[(e0 + 1) % 64] - en_cyc[e0 % 64] < 158 || en_cyc[(e0 + 1) % 64] - en_cyc[e0 % 64] > 162) begin
      errors++; $display("FAIL b2b_gap: got %0d want 160+/-2", en_cyc[(e0 + 1) % 64] - en_cyc[e0 % 64]);
    end
  endtask
  task automatic test_glitch;
    int e0, f0;
    e0 = en_cnt; f0 = fe_cnt;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    tick(188);
    checks++; if (en_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_en: got %0d want 0", en_cnt - e0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - f0); end
  endtask
  task automatic test_frame_err;
    int e0, f0;
    e0 = en_cnt; f0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    tick(40);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); end
    checks++; if (en_cnt - e0 !== 0) begin errors++; $display("FAIL ferr_en: got %0d want 0", en_cnt - e0); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL ferr_data_held: got %h want ff", data_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
    RX = 1'b1;
    tick(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_exit: got %b want 0", busy); end
    send_byte(8'h3C, 1'b1);
    tick(20);
    checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL recover_pulses: got %0d want 1", en_cnt - e0); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL recover_data: got %h want 3c", data_out); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL recover_ferr: got %0d want 1", fe_cnt - f0); end
  endtask
  task automatic test_reset_mid;
    int e0, f0;
    logic [7:0] b;
    e0 = en_cnt; f0 = fe_cnt; b = 8'h81;
    RX = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      tick(16);
    end
    RX = b[4];
    tick(8);
    res = 1'b0;
    RX = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (en_data_out !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b want 00", en_data_out, frame_err); end
    tick(3);
    res = 1'b1;
    tick(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", busy); end
    checks++; if (en_cnt - e0 !== 0 || fe_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_nopulse: got %0d/%0d want 0/0", en_cnt - e0, fe_cnt - f0); end
    send_byte(8'h7E, 1'b1);
    tick(20);
    checks++; if (en_cnt - e0 !== 1) begin errors++; $display("FAIL midrst_after_pulses: got %0d want 1", en_cnt - e0); end
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL midrst_after_data: got %h want 7e", data_out); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive: got %0d overlaps want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
